snoop_bus_ctrl: RTL

//  N-core MSI snooping bus controller; generalises the 2-CPU bus to NUM_CPU requesters.

---
 rtl/snoop_bus_pkg.sv | 39 +++
 rtl/snoop_bus_ctrl_rr_arbiter.sv | 29 ++
 rtl/snoop_bus_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/snoop_bus_pkg.sv
// Shared types for the MSI snooping bus controller.
// Latency: n/a (types and a combinational helper only).
// Backpressure: n/a.
package snoop_bus_pkg;

   localparam int MAX_CPU = 8;

   typedef enum logic [1:0] {
      OP_IDLE = 2'b00,
      BUS_RD  = 2'b01,
      BUS_RDX = 2'b10,
      BUS_UPG = 2'b11
   } bus_op_t;

   typedef enum logic [1:0] {
      MSI_I    = 2'b00,
      MSI_S    = 2'b01,
      MSI_M    = 2'b10,
      MSI_RSVD = 2'b11
   } msi_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SNOOP,
      ST_EVAL,
      ST_FLUSH,
      ST_FILL,
      ST_DONE
   } ctrl_state_t;

   // Index of the lowest set bit; 0 when no bit is set.
   function automatic logic [2:0] lowest_idx(input logic [MAX_CPU-1:0] v);
      lowest_idx = '0;
      for (int i = MAX_CPU - 1; i >= 0; i--) begin
         if (v[i]) lowest_idx = 3'(i);
      end
   endfunction

endpackage

// File: rtl/snoop_bus_ctrl_rr_arbiter.sv
// Round-robin pick: first requester at or after ptr, wrapping modulo N.
// Latency: combinational.
// Backpressure: none; caller holds req until served.
// Ports: req (N requests), ptr (start index) -> gnt (one-hot), idx (binary), any (some request).
module rr_arbiter #(
   parameter int N = 2,
   parameter int W = 1
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [N-1:0] gnt,
   output logic [W-1:0] idx,
   output logic         any
);

   // Walk offsets from farthest to nearest so the nearest requester wins.
   always_comb begin
      gnt = '0;
      idx = '0;
      any = |req;
      for (int off = N - 1; off >= 0; off--) begin
         if (req[(int'(ptr) + off) % N]) begin
            gnt = N'(1) << ((int'(ptr) + off) % N);
            idx = W'((int'(ptr) + off) % N);
         end
      end
   end

endmodule

// File: rtl/snoop_bus_ctrl.sv
// MSI snooping bus controller: arbitrates NUM_CPU miss/upgrade requests, snoops, sources data.
// Latency: done 3 cycles after the IDLE latch cycle on a hit (4 cycles inclusive), plus memory cycles.
// Backpressure: requests held until done; memory phase waits on mem_rdy up to MEM_TIMEOUT cycles.
// Ports: req_rd/req_wr/req_upg/req_addr from caches; snoop_hit/snoop_dirty sampled in EVAL;
//        mem_rdy completes mem_re/mem_we; grant/bus_op/bus_addr/snoop_req/inv/downgrade/data_src/
//        fwd_src/done/new_state drive the caches; err is a sticky protocol/timeout flag.
module snoop_bus_ctrl
   import snoop_bus_pkg::*;
#(
   parameter int NUM_CPU     = 2,
   parameter int ADDR_W      = 11,
   parameter int MEM_TIMEOUT = 64
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_CPU-1:0]        req_rd,
   input  logic [NUM_CPU-1:0]        req_wr,
   input  logic [NUM_CPU-1:0]        req_upg,
   input  logic [NUM_CPU*ADDR_W-1:0] req_addr,
   input  logic [NUM_CPU-1:0]        snoop_hit,
   input  logic [NUM_CPU-1:0]        snoop_dirty,
   input  logic                      mem_rdy,
   output logic [NUM_CPU-1:0]        grant,
   output logic [1:0]                bus_op,
   output logic [ADDR_W-1:0]         bus_addr,
   output logic [NUM_CPU-1:0]        snoop_req,
   output logic [NUM_CPU-1:0]        inv,
   output logic [NUM_CPU-1:0]        downgrade,
   output logic                      data_src,
   output logic [((NUM_CPU > 1) ? $clog2(NUM_CPU) : 1)-1:0] fwd_src,
   output logic                      mem_re,
   output logic                      mem_we,
   output logic [NUM_CPU-1:0]        done,
   output logic [1:0]                new_state,
   output logic                      err
);

   localparam int IDX_W = (NUM_CPU > 1) ? $clog2(NUM_CPU) : 1;
   localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

   ctrl_state_t         state_q, state_d;
   logic [NUM_CPU-1:0]  any_req, arb_gnt;
   logic [IDX_W-1:0]    arb_idx;
   logic                arb_any;

   logic [NUM_CPU-1:0]  grant_q;
   logic [IDX_W-1:0]    id_q, rr_ptr_q, fsrc_q;
   bus_op_t             op_q;
   logic [ADDR_W-1:0]   addr_q;
   msi_t                ns_q;
   logic                dsrc_q, err_q;
   logic [CNT_W-1:0]    cnt_q;
   logic                tmo;

   logic [NUM_CPU-1:0]  hit_m, dirty_m, ev_inv, ev_dg;
   logic                ev_dsrc, ev_multi;
   logic [IDX_W-1:0]    ev_fsrc, lo_dirty, lo_hit;
   msi_t                ev_ns;
   ctrl_state_t         ev_next;

   assign any_req = req_rd | req_wr | req_upg;

   rr_arbiter #(.N(NUM_CPU), .W(IDX_W)) u_arb (
      .req (any_req),
      .ptr (rr_ptr_q),
      .gnt (arb_gnt),
      .idx (arb_idx),
      .any (arb_any)
   );

   // mem_rdy on the last allowed cycle still counts as success.
   assign tmo = (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) && !mem_rdy;

   // Snoop evaluation; the owner's own hit/dirty is masked out.
   always_comb begin
      hit_m    = snoop_hit & ~grant_q;
      dirty_m  = snoop_dirty & ~grant_q;
      lo_dirty = IDX_W'(lowest_idx(MAX_CPU'(dirty_m)));
      lo_hit   = IDX_W'(lowest_idx(MAX_CPU'(hit_m)));
      ev_multi = |(dirty_m & (dirty_m - NUM_CPU'(1)));
      ev_inv   = '0;
      ev_dg    = '0;
      ev_dsrc  = 1'b0;
      ev_fsrc  = '0;
      ev_ns    = MSI_S;
      ev_next  = ST_DONE;
      case (op_q)
         BUS_UPG: begin
            ev_inv = hit_m;
            ev_ns  = MSI_M;
         end
         BUS_RDX: begin
            ev_inv = hit_m;
            ev_ns  = MSI_M;
            if (|dirty_m) begin
               ev_dsrc = 1'b1;
               ev_fsrc = lo_dirty;
            end else begin
               ev_next = ST_FILL;
            end
         end
         default: begin
            if (|dirty_m) begin
               ev_dsrc = 1'b1;
               ev_fsrc = lo_dirty;
               ev_dg   = dirty_m & ~(dirty_m - NUM_CPU'(1));  // lowest dirty, one-hot
               ev_next = ST_FLUSH;
            end else if (|hit_m) begin
               ev_dsrc = 1'b1;
               ev_fsrc = lo_hit;
            end else begin
               ev_next = ST_FILL;
            end
         end
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (arb_any) state_d = ST_SNOOP;
         ST_SNOOP: state_d = ST_EVAL;
         ST_EVAL:  state_d = ev_next;
         ST_FLUSH,
         ST_FILL:  if (mem_rdy || tmo) state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Transaction registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant_q  <= '0;
         id_q     <= '0;
         rr_ptr_q <= '0;
         op_q     <= OP_IDLE;
         addr_q   <= '0;
         ns_q     <= MSI_I;
         dsrc_q   <= 1'b0;
         fsrc_q   <= '0;
         cnt_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (arb_any) begin
                  grant_q <= arb_gnt;
                  id_q    <= arb_idx;
                  addr_q  <= req_addr[int'(arb_idx)*ADDR_W +: ADDR_W];
                  op_q    <= req_upg[arb_idx] ? BUS_UPG :
                             req_wr[arb_idx]  ? BUS_RDX : BUS_RD;
                  dsrc_q  <= 1'b0;
                  fsrc_q  <= '0;
               end
            end
            ST_EVAL: begin
               ns_q   <= ev_ns;
               dsrc_q <= ev_dsrc;
               fsrc_q <= ev_fsrc;
               cnt_q  <= '0;
               if (ev_multi) err_q <= 1'b1;
            end
            ST_FLUSH,
            ST_FILL: begin
               cnt_q <= cnt_q + CNT_W'(1);
               if (tmo) begin
                  err_q <= 1'b1;
                  ns_q  <= MSI_I;
               end
            end
            ST_DONE: begin
               rr_ptr_q <= (id_q == IDX_W'(NUM_CPU - 1)) ? '0 : id_q + IDX_W'(1);
            end
            default: ;
         endcase
      end
   end

   // Outputs
   always_comb begin
      grant     = '0;
      bus_op    = OP_IDLE;
      bus_addr  = '0;
      snoop_req = '0;
      inv       = '0;
      downgrade = '0;
      data_src  = 1'b0;
      fwd_src   = '0;
      mem_re    = 1'b0;
      mem_we    = 1'b0;
      done      = '0;
      new_state = MSI_I;
      if (state_q != ST_IDLE) begin
         grant    = grant_q;
         bus_op   = op_q;
         bus_addr = addr_q;
      end
      case (state_q)
         ST_SNOOP: snoop_req = ~grant_q;
         ST_EVAL: begin
            inv       = ev_inv;
            downgrade = ev_dg;
            data_src  = ev_dsrc;
            fwd_src   = ev_fsrc;
         end
         ST_FLUSH: begin
            mem_we   = 1'b1;
            data_src = dsrc_q;
            fwd_src  = fsrc_q;
         end
         ST_FILL: begin
            mem_re   = 1'b1;
            data_src = dsrc_q;
            fwd_src  = fsrc_q;
         end
         ST_DONE: begin
            data_src  = dsrc_q;
            fwd_src   = fsrc_q;
            done      = grant_q;
            new_state = ns_q;
         end
         default: ;
      endcase
   end

   assign err = err_q;

endmodule
